// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input valid/ready stream multiplexer with round-robin arbitration
// and a registered output stage. The arbiter searches for a valid channel starting
// at the priority pointer; the winner is loaded into the output register whenever
// that register is empty or draining in the same cycle.
//
// Optional packet lock: define RR_ARB_MUX_PKT_LOCK_EN to hold the grant on one
// channel from its first beat until the beat carrying s_last.
module rr_arb_mux #(
    parameter int width = 32,
    parameter int N     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         s_valid,
    output logic [N-1:0]         s_ready,
    input  logic [width-1:0]     s_data [0:N-1],
    input  logic [N-1:0]         s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [width-1:0]     m_data,
    output logic [$clog2(N)-1:0] m_sel,
    output logic                 m_last
);

    localparam int SelW = $clog2(N);

    logic [SelW-1:0]  ptr_q, ptr_d;
    logic             m_valid_q, m_valid_d;
    logic [width-1:0] m_data_q, m_data_d;
    logic [SelW-1:0]  m_sel_q, m_sel_d;
    logic             m_last_q, m_last_d;

    logic [N-1:0]     grant;
    logic [SelW-1:0]  gnt_idx;
    logic             found;
    logic             load_en;
    logic             in_xfer;
    logic [SelW-1:0]  ptr_after;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    // While locked, the held output beat's m_sel names the owning channel.
    logic lock_q, lock_d;
`endif

    assign load_en = !m_valid_q || m_ready;
    assign s_ready = load_en ? grant : '0;
    assign in_xfer = |(s_valid & s_ready);

    // Pointer value following the granted channel, wrapping N-1 -> 0.
    assign ptr_after = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

    // Round-robin grant: first valid channel at or after ptr, modulo N.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && s_valid[(int'(ptr_q) + j) % N]) begin
                found   = 1'b1;
                gnt_idx = SelW'((int'(ptr_q) + j) % N);
            end
        end
        if (found) begin
            grant[gnt_idx] = 1'b1;
        end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        // Locked: grant the owner even when it is idle, producing bubbles.
        if (lock_q) begin
            grant          = '0;
            grant[m_sel_q] = 1'b1;
            gnt_idx        = m_sel_q;
        end
`endif
    end

    // Next-state for the output register, priority pointer and lock.
    always_comb begin
        ptr_d     = ptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sel_d   = m_sel_q;
        m_last_d  = m_last_q;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        lock_d    = lock_q;
`endif
        if (load_en) begin
            m_valid_d = in_xfer;
            if (in_xfer) begin
                m_data_d = s_data[gnt_idx];
                m_sel_d  = gnt_idx;
                m_last_d = s_last[gnt_idx];
`ifdef RR_ARB_MUX_PKT_LOCK_EN
                // Pointer only moves when a packet completes.
                lock_d = !s_last[gnt_idx];
                if (s_last[gnt_idx]) begin
                    ptr_d = ptr_after;
                end
`else
                ptr_d = ptr_after;
`endif
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sel_q   <= '0;
            m_last_q  <= 1'b0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sel_q   <= m_sel_d;
            m_last_q  <= m_last_d;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sel   = m_sel_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (N=4, width=32): directed scenarios plus a
// randomized phase, all compared against a behavioural model and a per-channel
// scoreboard of beats in flight.
module tb_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic [N-1:0]  s_valid;
    logic [N-1:0]  s_ready;
    logic [W-1:0]  s_data [0:N-1];
    logic [N-1:0]  s_last;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [1:0]    m_sel;
    logic          m_last;

    rr_arb_mux #(
        .width(W),
        .N    (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_sel  (m_sel),
        .m_last (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          e_valid;
    logic [W-1:0]  e_data;
    int            e_sel;
    logic          e_last;
    int            e_ptr;
    logic          e_lock;
    int            e_lock_ch;
    logic [N-1:0]  model_xfer;
    logic [W:0]    sb [0:N-1][$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid   = 1'b0;
        e_data    = '0;
        e_sel     = 0;
        e_last    = 1'b0;
        e_ptr     = 0;
        e_lock    = 1'b0;
        e_lock_ch = 0;
        for (int i = 0; i < N; i++) sb[i].delete();
    endtask

    // Winner under the arbitration rules, or -1 when nobody qualifies.
    function automatic int pick();
        if (e_lock) return e_lock_ch;
        for (int off = 0; off < N; off++) begin
            if (s_valid[(e_ptr + off) % N]) return (e_ptr + off) % N;
        end
        return -1;
    endfunction

    // One clock: check DUT against the model at the falling edge, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic cycle();
        int           g;
        logic         load;
        logic [N-1:0] rdy;
        logic [W:0]   ent;
        @(negedge clk);
        load = !e_valid || m_ready;
        g    = pick();
        rdy  = '0;
        if (load && g >= 0) rdy[g] = 1'b1;
        check_eq("s_ready", 64'(s_ready), 64'(rdy));
        check_eq("m_valid", 64'(m_valid), 64'(e_valid));
        check_eq("m_data",  64'(m_data),  64'(e_data));
        check_eq("m_sel",   64'(m_sel),   64'(e_sel));
        check_eq("m_last",  64'(m_last),  64'(e_last));
        if (!rst && m_valid && m_ready) begin
            check_eq("sb_nonempty", 64'(sb[m_sel].size() != 0), 64'd1);
            if (sb[m_sel].size() != 0) begin
                ent = sb[m_sel].pop_front();
                check_eq("sb_beat", 64'({m_last, m_data}), 64'(ent));
            end
        end
        model_xfer = '0;
        if (rst) begin
            model_reset();
        end else if (load) begin
            if (g >= 0 && s_valid[g]) begin
                e_valid       = 1'b1;
                e_data        = s_data[g];
                e_sel         = g;
                e_last        = s_last[g];
                model_xfer[g] = 1'b1;
                sb[g].push_back({s_last[g], s_data[g]});
`ifdef RR_ARB_MUX_PKT_LOCK_EN
                if (!s_last[g]) begin
                    e_lock    = 1'b1;
                    e_lock_ch = g;
                end else begin
                    e_lock = 1'b0;
                    e_ptr  = (g + 1) % N;
                end
`else
                e_ptr = (g + 1) % N;
`endif
            end else begin
                e_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         got_seq[$];
        int         exp_seq[4];
        int         beat;
        logic       ch0_started;
        logic [W-1:0] held_data;
        logic [1:0]   held_sel;

        model_reset();
        model_xfer = '0;
        rst     = 1'b1;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b0;
        for (int i = 0; i < N; i++) s_data[i] = '0;
        @(posedge clk);
        #1;

        // Reset held for two cycles
        cycle();
        cycle();
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_data",  64'(m_data),  64'd0);
        check_eq("rst_m_sel",   64'(m_sel),   64'd0);
        check_eq("rst_m_last",  64'(m_last),  64'd0);
        check_eq("rst_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;

        // Single channel
        s_valid   = 4'b0100;
        s_data[2] = 32'hCCCC_CCCC;
        m_ready   = 1'b1;
        #1;
        check_eq("single_s_ready", 64'(s_ready), 64'b0100);
        cycle();
        check_eq("single_m_valid", 64'(m_valid), 64'd1);
        check_eq("single_m_data",  64'(m_data),  64'hCCCC_CCCC);
        check_eq("single_m_sel",   64'(m_sel),   64'd2);
        s_valid = '0;
        cycle();

        // Reset in the middle of a stream
        for (int i = 0; i < N; i++) s_data[i] = 32'hAAAA_AAAA + 32'(i);
        s_valid = 4'b1111;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_eq("midrst_m_valid", 64'(m_valid), 64'd0);
        rst     = 1'b0;
        s_valid = 4'b0110;
        cycle();
        check_eq("midrst_first_sel", 64'(m_sel), 64'd1);
        check_eq("midrst_first_vld", 64'(m_valid), 64'd1);

        // Round robin from ptr=0, all channels valid
        rst = 1'b1;
        cycle();
        rst     = 1'b0;
        s_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            cycle();
            check_eq("rr_m_valid", 64'(m_valid), 64'd1);
            check_eq("rr_m_sel",   64'(m_sel),   64'(c % N));
            check_eq("rr_m_data",  64'(m_data),  64'(32'hAAAA_AAAA + 32'(c % N)));
        end

        // Backpressure: stall three cycles, then release
        m_ready = 1'b0;
        held_data = m_data;
        held_sel  = m_sel;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("bp_s_ready", 64'(s_ready), 64'd0);
            cycle();
            check_eq("bp_m_data_hold", 64'(m_data), 64'(held_data));
            check_eq("bp_m_sel_hold",  64'(m_sel),  64'(held_sel));
        end
        m_ready = 1'b1;
        cycle();
        check_eq("bp_release_sel", 64'(m_sel), 64'd0);
        s_valid = '0;
        cycle();

        // Wrap and skip: ptr=3, channels 0 and 1 valid
        rst = 1'b1;
        cycle();
        rst     = 1'b0;
        s_valid = 4'b0100;
        cycle();
        s_valid = 4'b0011;
        cycle();
        check_eq("wrap_sel0", 64'(m_sel), 64'd0);
        cycle();
        check_eq("wrap_sel1", 64'(m_sel), 64'd1);
        s_valid = '0;
        cycle();

        // Packet scenario: channel 1 sends 3 beats, channel 0 joins after beat 1
        rst = 1'b1;
        cycle();
        rst         = 1'b0;
        m_ready     = 1'b1;
        beat        = 0;
        ch0_started = 1'b0;
        s_data[0]   = 32'h0000_0F00;
        s_last[0]   = 1'b1;
        s_data[1]   = 32'h1000_0000;
        s_last[1]   = 1'b0;
        s_valid     = 4'b0010;
        for (int c = 0; c < 12 && got_seq.size() < 4; c++) begin
            cycle();
            if (m_valid) got_seq.push_back(int'(m_sel));
            if (model_xfer[0]) s_valid[0] = 1'b0;
            if (model_xfer[1]) begin
                beat++;
                if (beat == 3) begin
                    s_valid[1] = 1'b0;
                end else begin
                    s_data[1] = 32'h1000_0000 + 32'(beat);
                    s_last[1] = (beat == 2);
                end
            end
            if (beat >= 1 && !ch0_started) begin
                ch0_started = 1'b1;
                s_valid[0]  = 1'b1;
            end
        end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        exp_seq = '{1, 1, 1, 0};
`else
        exp_seq = '{1, 0, 1, 1};
`endif
        check_eq("pkt_beats", 64'(got_seq.size()), 64'd4);
        for (int i = 0; i < got_seq.size() && i < 4; i++) begin
            check_eq("pkt_sel", 64'(got_seq[i]), 64'(exp_seq[i]));
        end
        s_valid = '0;
        s_last  = '0;
        cycle();

        // Randomized traffic against the model and scoreboard
        for (int c = 0; c < 400; c++) begin
            s_valid = 4'($urandom);
            s_last  = 4'($urandom);
            for (int i = 0; i < N; i++) s_data[i] = $urandom;
            m_ready = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst     = 1'b0;
        s_valid = '0;
        m_ready = 1'b1;
        cycle();
        cycle();
        check_eq("drain_m_valid", 64'(m_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
